// File: rtl/phold_event_core.sv
// PHOLD logical-process event core.
// Takes one event and does a read-modify-write of the target LP's state word
// over the shared MC port. It then offers one new random event to the scheduler.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new event
// RD_REQ  | RD8 request to the LP state word, held until granted
// RD_WAIT | waiting for RD8 data tagged with this core's id
// WR_REQ  | WR8 of the updated state word, held until granted
// WR_WAIT | waiting for the write completion tagged with this core's id
// SEND    | generated event offered to the scheduler until ack

`ifndef TW
`define TW 16
`endif

module phold_event_core #(
   parameter int NIDB            = 3,
   parameter int NRB             = 8,
   parameter int NCB             = 2,
   parameter int MC_RTNCTL_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NCB-1:0]             core_id,
   input  logic                       event_valid,
   input  logic [NIDB-1:0]            event_id,
   input  logic [`TW-1:0]             event_time,
   input  logic [`TW-1:0]             global_time,
   input  logic [NRB-1:0]             random_in,
   output logic [`TW-1:0]             new_event_time,
   output logic [NIDB-1:0]            new_event_target,
   output logic                       new_event_ready,
   output logic                       ready,
   input  logic                       ack,
   output logic                       mc_rq_vld,
   output logic [2:0]                 mc_rq_cmd,
   output logic [3:0]                 mc_rq_scmd,
   output logic [47:0]                mc_rq_vadr,
   output logic [1:0]                 mc_rq_size,
   output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
   output logic [63:0]                mc_rq_data,
   output logic                       mc_rq_flush,
   input  logic                       mc_rq_stall,
   input  logic                       mc_rs_vld,
   input  logic [2:0]                 mc_rs_cmd,
   input  logic [3:0]                 mc_rs_scmd,
   input  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
   input  logic [63:0]                mc_rs_data,
   output logic                       mc_rs_stall,
   input  logic [47:0]                addr,
   input  logic                       mem_gnt
);

   localparam int TW = `TW;

   // Convey MC command encodings (aemc_messages.vh)
   localparam logic [2:0] MCAE_CMD_RD8      = 3'd1;
   localparam logic [2:0] MCAE_CMD_WR8      = 3'd2;
   localparam logic [2:0] MCAE_CMD_RD8_DATA = 3'd2;
   localparam logic [2:0] MCAE_CMD_WR_CMP   = 3'd3;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, SEND} state_t;

   state_t            state_q, state_d;
   logic [NIDB-1:0]   id_q, id_d;
   logic [TW-1:0]     time_q, time_d;
   logic [NRB-1:0]    rnd_q, rnd_d;
   // Only bits [63:TW] of the old word survive into the write-back.
   logic [63-TW:0]    old_q, old_d;
   logic [TW-1:0]     ntime_q, ntime_d;

   logic [47:0]       req_vadr;
   logic [63:0]       wr_data;
   logic              rs_match;
   logic [TW:0]       sum_w, floor_w;
   logic [TW-1:0]     sat_v, floor_v, ntime_calc;
   logic              rs_unused;

   assign mc_rq_scmd  = 4'd0;
   assign mc_rq_flush = 1'b0;
   assign mc_rs_stall = 1'b0;

   assign req_vadr = addr + {{(48-NIDB-3){1'b0}}, id_q, 3'b000};
   assign wr_data  = {old_q[63-TW:32-TW] + 32'd1, old_q[31-TW:0], time_q};
   assign rs_match = mc_rs_vld && (mc_rs_rtnctl[NCB-1:0] == core_id);
   assign rs_unused = ^{mc_rs_scmd, mc_rs_rtnctl[MC_RTNCTL_WIDTH-1:NCB], mc_rs_data[TW-1:0]};

   // New timestamp: event time + random + 1, saturated, then floored at GVT+1.
   always_comb begin
      sum_w      = {1'b0, time_q} + {{(TW+1-NRB){1'b0}}, rnd_q} + (TW+1)'(1);
      floor_w    = {1'b0, global_time} + (TW+1)'(1);
      sat_v      = sum_w[TW] ? '1 : sum_w[TW-1:0];
      floor_v    = floor_w[TW] ? '1 : floor_w[TW-1:0];
      ntime_calc = (sat_v < floor_v) ? floor_v : sat_v;
   end

   // Next-state, latch updates and decoded outputs.
   always_comb begin
      state_d          = state_q;
      id_d             = id_q;
      time_d           = time_q;
      rnd_d            = rnd_q;
      old_d            = old_q;
      ntime_d          = ntime_q;
      ready            = 1'b0;
      new_event_ready  = 1'b0;
      new_event_time   = '0;
      new_event_target = '0;
      mc_rq_vld        = 1'b0;
      mc_rq_cmd        = 3'd0;
      mc_rq_vadr       = '0;
      mc_rq_size       = 2'd0;
      mc_rq_rtnctl     = '0;
      mc_rq_data       = '0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (event_valid) begin
               id_d    = event_id;
               time_d  = event_time;
               rnd_d   = random_in;
               state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            mc_rq_vld    = 1'b1;
            mc_rq_cmd    = MCAE_CMD_RD8;
            mc_rq_vadr   = req_vadr;
            mc_rq_size   = 2'd3;
            mc_rq_rtnctl = {{(MC_RTNCTL_WIDTH-NCB){1'b0}}, core_id};
            if (mem_gnt && !mc_rq_stall) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (rs_match && mc_rs_cmd == MCAE_CMD_RD8_DATA) begin
               old_d   = mc_rs_data[63:TW];
               state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            mc_rq_vld    = 1'b1;
            mc_rq_cmd    = MCAE_CMD_WR8;
            mc_rq_vadr   = req_vadr;
            mc_rq_size   = 2'd3;
            mc_rq_rtnctl = {{(MC_RTNCTL_WIDTH-NCB){1'b0}}, core_id};
            mc_rq_data   = wr_data;
            if (mem_gnt && !mc_rq_stall) state_d = WR_WAIT;
         end
         WR_WAIT: begin
            // Timestamp frozen here so it stays stable while waiting for ack.
            if (rs_match && mc_rs_cmd == MCAE_CMD_WR_CMP) begin
               ntime_d = ntime_calc;
               state_d = SEND;
            end
         end
         SEND: begin
            new_event_ready  = 1'b1;
            new_event_time   = ntime_q;
            new_event_target = rnd_q[NIDB-1:0];
            if (ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched-event registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         id_q    <= '0;
         time_q  <= '0;
         rnd_q   <= '0;
         old_q   <= '0;
         ntime_q <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         time_q  <= time_d;
         rnd_q   <= rnd_d;
         old_q   <= old_d;
         ntime_q <= ntime_d;
      end
   end

endmodule

// File: tb/tb_phold_event_core.sv
// Bench for phold_event_core: a small memory model of the LP state array plus
// arithmetic expectations for the address, the write data and the new timestamp.
module tb_phold_event_core;
   localparam logic [2:0] CMD_RD8     = 3'd1;
   localparam logic [2:0] CMD_WR8     = 3'd2;
   localparam logic [2:0] RS_RD8_DATA = 3'd2;
   localparam logic [2:0] RS_WR_CMP   = 3'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  core_id;
   logic        event_valid;
   logic [2:0]  event_id;
   logic [15:0] event_time, global_time;
   logic [7:0]  random_in;
   logic [15:0] new_event_time;
   logic [2:0]  new_event_target;
   logic        new_event_ready, ready, ack;
   logic        mc_rq_vld;
   logic [2:0]  mc_rq_cmd;
   logic [3:0]  mc_rq_scmd;
   logic [47:0] mc_rq_vadr;
   logic [1:0]  mc_rq_size;
   logic [31:0] mc_rq_rtnctl;
   logic [63:0] mc_rq_data;
   logic        mc_rq_flush, mc_rq_stall;
   logic        mc_rs_vld;
   logic [2:0]  mc_rs_cmd;
   logic [3:0]  mc_rs_scmd;
   logic [31:0] mc_rs_rtnctl;
   logic [63:0] mc_rs_data;
   logic        mc_rs_stall;
   logic [47:0] addr;
   logic        mem_gnt;

   int checks = 0;
   int errors = 0;
   logic [63:0] mem [8];

   always #5 clk = ~clk;

   phold_event_core dut (
      .clk(clk), .rst_n(rst_n), .core_id(core_id),
      .event_valid(event_valid), .event_id(event_id), .event_time(event_time),
      .global_time(global_time), .random_in(random_in),
      .new_event_time(new_event_time), .new_event_target(new_event_target),
      .new_event_ready(new_event_ready), .ready(ready), .ack(ack),
      .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
      .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
      .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
      .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
      .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall),
      .addr(addr), .mem_gnt(mem_gnt)
   );

   function automatic logic [15:0] exp_time(input int et, input int r, input int gt);
      int s, f;
      s = et + r + 1;
      if (s > 65535) s = 65535;
      f = gt + 1;
      if (f > 65535) f = 65535;
      if (s < f) s = f;
      return 16'(s);
   endfunction

   // Holds the request ungranted for gd cycles, stalled for sd cycles, then grants.
   task automatic grant_phase(input logic [2:0] cmd, input logic [47:0] va, input logic [63:0] wd,
                              input int gd, input int sd, input string nm);
      for (int i = 0; i <= gd + sd; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (mc_rq_vld !== 1'b1 || mc_rq_cmd !== cmd || mc_rq_vadr !== va || mc_rq_size !== 2'd3 ||
             mc_rq_rtnctl !== 32'(core_id) || mc_rq_scmd !== 4'd0 || mc_rq_flush !== 1'b0 ||
             (cmd == CMD_WR8 && mc_rq_data !== wd)) begin
            errors++;
            $display("FAIL %s_req cyc%0d: vld=%0b cmd=%0d vadr=%h size=%0d rtnctl=%h data=%h; want vld=1 cmd=%0d vadr=%h size=3 rtnctl=%h data=%h",
                     nm, i, mc_rq_vld, mc_rq_cmd, mc_rq_vadr, mc_rq_size, mc_rq_rtnctl, mc_rq_data,
                     cmd, va, 32'(core_id), wd);
         end
         ack         = 1'b1;
         mem_gnt     = (i >= gd);
         mc_rq_stall = (i >= gd) && (i < gd + sd);
      end
      @(negedge clk);
      mem_gnt = 1'b0; mc_rq_stall = 1'b0; ack = 1'b0;
      checks++;
      if (mc_rq_vld !== 1'b0) begin
         errors++;
         $display("FAIL %s_grant_drop: mc_rq_vld=%0b want 0", nm, mc_rq_vld);
      end
   endtask

   // Optionally injects a wrong-tag and a wrong-command response, then the real one after rd cycles.
   task automatic resp_phase(input logic [2:0] cmd, input logic [63:0] data, input int rd,
                             input bit junk, input string nm);
      logic [31:0] tag;
      if (junk) begin
         mc_rs_vld = 1'b1; mc_rs_cmd = cmd; mc_rs_rtnctl = 32'h1;
         mc_rs_data = {$urandom, $urandom};
         @(negedge clk);
         mc_rs_cmd = (cmd == RS_RD8_DATA) ? RS_WR_CMP : RS_RD8_DATA;
         mc_rs_rtnctl = 32'(core_id);
         @(negedge clk);
         mc_rs_vld = 1'b0;
         checks++;
         if (mc_rq_vld !== 1'b0 || new_event_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_filter: mc_rq_vld=%0b new_event_ready=%0b want 0 0", nm, mc_rq_vld, new_event_ready);
         end
      end
      repeat (rd) @(negedge clk);
      tag = $urandom;
      tag[1:0] = core_id;
      mc_rs_vld = 1'b1; mc_rs_cmd = cmd; mc_rs_rtnctl = tag; mc_rs_data = data;
      mc_rs_scmd = 4'($urandom);
      @(negedge clk);
      mc_rs_vld = 1'b0;
   endtask

   // One full event: accept, read, write, send, ack.
   task automatic run_event(input logic [2:0] id, input logic [15:0] et, input logic [7:0] rnd,
                            input logic [15:0] gt, input int gd, input int sd, input int rd,
                            input int ad, input bit junk, input bit b2b);
      logic [47:0] va;
      logic [63:0] wd;
      logic [15:0] etime;
      va    = addr + 48'(id) * 48'd8;
      wd    = {32'(mem[id][63:32] + 32'd1), mem[id][31:16], et};
      etime = exp_time(int'(et), int'(rnd), int'(gt));
      if (!b2b) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || new_event_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle: ready=%0b new_event_ready=%0b want 1 0", ready, new_event_ready);
      end
      event_valid = 1'b1; event_id = id; event_time = et; random_in = rnd; global_time = gt;
      @(negedge clk);
      // Keep event_valid high with junk fields: must be ignored while busy.
      event_id = 3'($urandom); event_time = 16'($urandom); random_in = 8'($urandom);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL accept: ready=%0b want 0", ready);
      end
      grant_phase(CMD_RD8, va, 64'd0, gd, sd, "rd");
      resp_phase(RS_RD8_DATA, mem[id], rd, junk, "rd");
      grant_phase(CMD_WR8, va, wd, gd, sd, "wr");
      resp_phase(RS_WR_CMP, {$urandom, $urandom}, rd, junk, "wr");
      mem[id] = wd;
      for (int i = 0; i <= ad; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (new_event_ready !== 1'b1 || new_event_time !== etime || new_event_target !== rnd[2:0]) begin
            errors++;
            $display("FAIL send cyc%0d: ready=%0b time=%h target=%0d; want 1 time=%h target=%0d",
                     i, new_event_ready, new_event_time, new_event_target, etime, rnd[2:0]);
         end
         global_time = 16'($urandom);
         random_in   = 8'($urandom);
      end
      event_valid = 1'b0;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (ready !== 1'b1 || new_event_ready !== 1'b0 || mc_rq_vld !== 1'b0) begin
         errors++;
         $display("FAIL after_ack: ready=%0b new_event_ready=%0b mc_rq_vld=%0b want 1 0 0",
                  ready, new_event_ready, mc_rq_vld);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #19;
      checks++;
      if (ready !== 1'b1 || mc_rq_vld !== 1'b0 || new_event_ready !== 1'b0 || mc_rs_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset: ready=%0b mc_rq_vld=%0b new_event_ready=%0b mc_rs_stall=%0b want 1 0 0 0",
                  ready, mc_rq_vld, new_event_ready, mc_rs_stall);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_read_write();
      core_id = 2'd3; addr = 48'hF0F0;
      mem[2] = 64'h0000_0000_0000_F0F0;
      // vadr 0xF100, write data 0x0000_0001_0000_0005, new time 0x16, target 0
      run_event(3'd2, 16'd5, 8'h10, 16'd0, 2, 0, 0, 0, 1'b0, 1'b0);
      run_event(3'd2, 16'd7, 8'h10, 16'd0, 0, 0, 1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_event(3'd4, 16'd10, 8'h23, 16'd0, 0, 0, 0, 0, 1'b0, 1'b1);
      run_event(3'd7, 16'd100, 8'h01, 16'd0, 0, 0, 0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_stall_ack();
      run_event(3'd1, 16'd40, 8'h05, 16'd0, 1, 3, 0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_filter_saturation();
      run_event(3'd3, 16'hFFF0, 8'hFF, 16'd0, 0, 0, 0, 0, 1'b1, 1'b0);
      run_event(3'd5, 16'h0005, 8'h01, 16'h1000, 0, 0, 2, 0, 1'b1, 1'b0);
      run_event(3'd6, 16'hFF00, 8'hFE, 16'h0100, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      event_valid = 1'b1; event_id = 3'd1; event_time = 16'd9; random_in = 8'd3;
      @(negedge clk);
      event_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || mc_rq_vld !== 1'b0 || new_event_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: ready=%0b mc_rq_vld=%0b new_event_ready=%0b want 1 0 0",
                  ready, mc_rq_vld, new_event_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mc_rs_vld = 1'b1; mc_rs_cmd = RS_RD8_DATA; mc_rs_rtnctl = 32'(core_id);
      @(negedge clk);
      mc_rs_vld = 1'b0;
      checks++;
      if (ready !== 1'b1 || mc_rq_vld !== 1'b0) begin
         errors++;
         $display("FAIL stale_resp: ready=%0b mc_rq_vld=%0b want 1 0", ready, mc_rq_vld);
      end
   endtask

   task automatic test_random();
      logic [15:0] gt;
      addr = {16'd0, 32'($urandom)};
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 3) == 0) gt = 16'($urandom_range(0, 16'hFFFE));
         else gt = 16'($urandom_range(0, 255));
         run_event(3'($urandom), 16'($urandom), 8'($urandom), gt,
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(0, 3), (n % 4) == 0, (n % 3) == 0);
      end
   endtask

   initial begin
      core_id = 2'd3; addr = 48'hF0F0;
      event_valid = 1'b0; event_id = '0; event_time = '0; global_time = '0; random_in = '0;
      ack = 1'b0; mc_rq_stall = 1'b0; mem_gnt = 1'b0;
      mc_rs_vld = 1'b0; mc_rs_cmd = '0; mc_rs_scmd = '0; mc_rs_rtnctl = '0; mc_rs_data = '0;
      for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
      test_reset();
      test_read_write();
      test_back_to_back();
      test_stall_ack();
      test_filter_saturation();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/phold_event_core.md
# phold_event_core

PHOLD logical-process (LP) event-processing core for the PDES accelerator. It accepts one event at a time from the scheduler, then performs a read-modify-write of the target LP's 64-bit state word through a Convey MC port arbitrated by `mem_gnt`. Finally it emits one new random event (target, timestamp) back to the scheduler under a ready/ack handshake.

## Interface
Parameters:
- `NIDB`, 3: LP id width; there are 2^NIDB LPs.
- `NRB`, 8: width of the random input.
- `NCB`, 2: core id width.
- `MC_RTNCTL_WIDTH`, 32: width of the MC return-control field.
- Timestamp width is the `TW` macro (16).

Ports:
- One clock; reset is asynchronous and active-low. The ports are `clk` and `rst_n`.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `core_id`, in, NCB: this core's index, used as the MC return tag.
- `event_valid`, in, 1: an incoming event is present.
- `event_id`, in, NIDB: LP id of the incoming event.
- `event_time`, in, TW: timestamp of the incoming event.
- `global_time`, in, TW: GVT floor (minimum timestamp).
- `random_in`, in, NRB: random source.
- `new_event_time`, out, TW: timestamp of the generated event.
- `new_event_target`, out, NIDB: target LP of the generated event.
- `new_event_ready`, out, 1: generated event is valid; held until `ack`.
- `ready`, out, 1: core is idle and can accept an event.
- `ack`, in, 1: scheduler has consumed the generated event.
- `mc_rq_vld`, `mc_rq_cmd`[2:0], `mc_rq_scmd`[3:0], `mc_rq_vadr`[47:0], `mc_rq_size`[1:0], `mc_rq_rtnctl`[MC_RTNCTL_WIDTH], `mc_rq_data`[63:0], `mc_rq_flush`: out, MC request.
- `mc_rq_stall`, in, 1: MC back-pressure.
- `mc_rs_vld`, `mc_rs_cmd`[2:0], `mc_rs_scmd`[3:0], `mc_rs_rtnctl`, `mc_rs_data`[63:0]: in, MC response.
- `mc_rs_stall`, out, 1: tied to 0.
- `addr`, in, 48: base address of the LP state array.
- `mem_gnt`, in, 1: arbiter grant for the shared MC request port.

## Operation
States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, SEND.

- **IDLE** (`ready`=1):
  - Acceptance condition is `event_valid && ready` at a clock edge.
  - On acceptance, latch `event_id`, `event_time` and `random_in`.
  - Go to RD_REQ.
- **RD_REQ**:
  - `mc_rq_vld`=1, `mc_rq_cmd`=MCAE_CMD_RD8, `mc_rq_size`=2'd3.
  - `mc_rq_vadr` = `addr` + (`event_id` << 3).
  - `mc_rq_rtnctl` = `core_id`, zero-extended.
  - The request is accepted on the edge where `mc_rq_vld && mem_gnt && !mc_rq_stall`; then go to RD_WAIT.
- **RD_WAIT**:
  - Wait for `mc_rs_vld` with `mc_rs_cmd`=MCAE_CMD_RD8_DATA and `mc_rs_rtnctl[NCB-1:0]`==`core_id`.
  - Latch `mc_rs_data` and go to WR_REQ.
  - Responses with any other tag or command are ignored.
- **WR_REQ**:
  - Same address, rtnctl and size as RD_REQ; `mc_rq_cmd`=MCAE_CMD_WR8.
  - `mc_rq_data` = {old[63:32]+1, old[31:TW], `event_time`}, i.e. increment the per-LP event count and record the LP's local virtual time.
  - Accepted under the same grant rule as RD_REQ; then go to WR_WAIT.
- **WR_WAIT**: wait for a matching `mc_rs_vld` with MCAE_CMD_WR_CMP, then go to SEND.
- **SEND**:
  - `new_event_ready`=1.
  - `new_event_target` = latched `random_in[NIDB-1:0]`.
  - `new_event_time` = `event_time` + `random_in` + 1, with `random_in` zero-extended. Saturate to all-ones on overflow, and floor at `global_time`+1.
  - On `ack`, go to IDLE.
- Fixed outputs:
  - `mc_rq_scmd`=0, `mc_rq_flush`=0, `mc_rs_stall`=0.
  - `mc_rq_vld`=0 outside RD_REQ and WR_REQ.
  - Command encodings come from the codebase's `aemc_messages.vh`.

## Timing
- Reset (asynchronous, `rst_n` low), taking effect immediately, including mid-transaction:
  - State goes to IDLE and all outputs are 0 except `ready`=1.
  - Any outstanding MC response arriving after reset is ignored (state is IDLE).
- `ready` drops the cycle after acceptance. `event_valid` is ignored whenever `ready`=0.
- `mc_rq_vld` is high from the cycle after acceptance and stays high, with stable fields, until the grant edge.
- `mem_gnt` may arrive in the same cycle `mc_rq_vld` rises, or any number of cycles later.
- A response may arrive at the earliest on the edge after the grant edge; there is no upper latency bound.
- Minimum latency from acceptance to `new_event_ready` is 5 cycles, with grant and responses immediate.
- `new_event_ready`, `new_event_time` and `new_event_target` are stable until `ack` is sampled.
- `ready`=1 the cycle after `ack`. A new event may be accepted on the following edge.
- `ack` outside SEND is ignored.

## Test plan
- **Reset:** drive `rst_n` low for 20 ns -> `ready`=1, `mc_rq_vld`=0, `new_event_ready`=0.
- **Read phase:** `core_id`=3, `addr`=0xF0F0; send event id 2, time 5, with `random_in`=0x10 -> RD8 request with vadr=0xF100, rtnctl=3, held until `mem_gnt`.
- **Write phase:**
  - Stimulus: return RD8_DATA 0xF0F0 with rtnctl=3.
  - Required: WR8 request to 0xF100 with data 0x0000_0001_0000_0005.
  - Stimulus: return WR_CMP two cycles after the grant.
  - Required: `new_event_ready`=1, time=0x16, target=0.
- **Ack / back-to-back:** pulse `ack`, then present event id 4, time 10 on the next edge -> accepted, `ready`=0; request vadr = 0xF0F0+32.
- **Stall and ack timing:** hold `mc_rq_stall` with `mem_gnt` high -> no acceptance until stall drops. Delay `ack` by 20 ns -> outputs remain stable.
- **Filtering and saturation:**
  - A response with rtnctl=1 is ignored.
  - Event time 0xFFF0 with `random_in`=0xFF -> `new_event_time`=0xFFFF.
